pixel_writeback_arbiter: RTL and testbench

- Sits directly downstream of the raymarcher lanes and upstream of the frame-buffer write port A.
- Collects finished pixels (x, y, colour) from NUM_LANES raymarchers through a valid/ready handshake.
- Round-robin arbitrates the lanes onto the single frame-buffer write port and computes the linear address x + WIDTH*y.
- Flags end-of-frame, so several raymarchers can run in parallel without write collisions.

---
 rtl/render_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 67 ++++++
 rtl/pixel_writeback_arbiter.sv | 142 ++++++++++++++
 tb/tb_pixel_writeback_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/render_pkg.sv
// Shared rendering types: default frame geometry, the pixel record that the
// raymarcher lanes hand over, and the frame-buffer address computation.
package render_pkg;

  localparam int unsigned DEF_NUM_LANES  = 3;
  localparam int unsigned DEF_WIDTH      = 1280;
  localparam int unsigned DEF_HEIGHT     = 720;
  localparam int unsigned DEF_COLOR_BITS = 24;

  localparam int unsigned X_W    = $clog2(DEF_WIDTH);
  localparam int unsigned Y_W    = $clog2(DEF_HEIGHT);
  localparam int unsigned ADDR_W = $clog2(DEF_WIDTH * DEF_HEIGHT);
  localparam int unsigned CNT_W  = ADDR_W + 1;

  typedef struct packed {
    logic [X_W-1:0]            x;
    logic [Y_W-1:0]            y;
    logic [DEF_COLOR_BITS-1:0] color;
  } pixel_t;

  // Row-major linear address, evaluated at full address width so the
  // product WIDTH*y cannot be truncated to the coordinate width.
  function automatic logic [ADDR_W-1:0] pixel_addr(input logic [X_W-1:0] x,
                                                   input logic [Y_W-1:0] y);
    return ADDR_W'(x) + ADDR_W'(DEF_WIDTH) * ADDR_W'(y);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first request at or after the pointer
// (wrapping), and moves the pointer just past the winner. No request leaves
// the pointer where it is.
module rr_arbiter #(
  parameter int unsigned N = 3,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic [N-1:0]  req_in,
  output logic [N-1:0]  gnt_out,
  output logic [IW-1:0] gnt_idx_out,
  output logic          gnt_valid_out
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic [IW:0]   cand_w;
  logic [IW-1:0] idx_s;
  logic          found_s;

  // Scan requests starting at the pointer, wrapping modulo N.
  always_comb begin
    found_s = 1'b0;
    idx_s   = '0;
    cand_w  = '0;
    for (int unsigned off = 0; off < N; off++) begin
      cand_w = {1'b0, ptr_q} + (IW+1)'(off);
      if (cand_w >= (IW+1)'(N)) begin
        cand_w = cand_w - (IW+1)'(N);
      end else begin
        cand_w = cand_w;
      end
      if (!found_s && req_in[cand_w[IW-1:0]]) begin
        found_s = 1'b1;
        idx_s   = cand_w[IW-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next pointer sits one past the winner; idle cycles keep it.
  always_comb begin
    if (!found_s) begin
      ptr_d = ptr_q;
    end else if (idx_s == IW'(N - 1)) begin
      ptr_d = '0;
    end else begin
      ptr_d = idx_s + IW'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign gnt_out       = found_s ? (N'(1) << idx_s) : '0;
  assign gnt_idx_out   = idx_s;
  assign gnt_valid_out = found_s;

endmodule

// File: rtl/pixel_writeback_arbiter.sv
// Collects finished pixels from several raymarcher lanes (one hold slot per
// lane), round-robins them onto the single frame-buffer write port through a
// two-stage pipeline, range-checks coordinates and flags end-of-frame.
// Geometry parameters are expected to match the render_pkg defaults, which
// size the pixel record.
module pixel_writeback_arbiter
  import render_pkg::*;
#(
  parameter int unsigned NUM_LANES  = DEF_NUM_LANES,
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned HEIGHT     = DEF_HEIGHT,
  parameter int unsigned COLOR_BITS = DEF_COLOR_BITS
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic [NUM_LANES-1:0]                 lane_valid_in,
  output logic [NUM_LANES-1:0]                 lane_ready_out,
  input  logic [NUM_LANES*$clog2(WIDTH)-1:0]   lane_x_in,
  input  logic [NUM_LANES*$clog2(HEIGHT)-1:0]  lane_y_in,
  input  logic [NUM_LANES*COLOR_BITS-1:0]      lane_color_in,
  output logic                                 wr_en_out,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]      wr_addr_out,
  output logic [COLOR_BITS-1:0]                wr_data_out,
  output logic                                 frame_done_out,
  output logic [$clog2(WIDTH*HEIGHT):0]        pixels_written_out,
  output logic                                 range_err_out
);

  localparam int unsigned XW = $clog2(WIDTH);
  localparam int unsigned YW = $clog2(HEIGHT);
  localparam int unsigned AW = $clog2(WIDTH * HEIGHT);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned IW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic [NUM_LANES-1:0] hold_valid_q;
  logic [NUM_LANES-1:0] hold_valid_d;
  pixel_t               hold_pix_q [NUM_LANES];

  logic [NUM_LANES-1:0] gnt_s;
  logic [IW-1:0]        gnt_idx_s;
  logic                 gnt_valid_s;

  logic                 s1_valid_q;
  pixel_t               s1_pix_q;
  logic                 s1_in_range_s;
  logic                 s1_last_s;
  logic                 s1_write_s;

  logic                 wr_en_q;
  logic [AW-1:0]        wr_addr_q;
  logic [COLOR_BITS-1:0] wr_data_q;
  logic                 frame_done_q;
  logic [CW-1:0]        cnt_q;
  logic                 range_err_q;

  // A slot is open whenever it is empty; never offered during reset.
  assign lane_ready_out = ~hold_valid_q & {NUM_LANES{~rst_in}};

  rr_arbiter #(.N(NUM_LANES)) u_rr (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .req_in        (hold_valid_q),
    .gnt_out       (gnt_s),
    .gnt_idx_out   (gnt_idx_s),
    .gnt_valid_out (gnt_valid_s)
  );

  // A granted slot empties; an open slot fills on a handshake. The two never
  // hit the same slot because a granted slot is full and therefore not ready.
  always_comb begin
    hold_valid_d = (hold_valid_q & ~gnt_s) | (lane_valid_in & lane_ready_out);
  end

  // Hold slots: capture x, y and colour on the handshake edge.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      hold_valid_q <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        hold_pix_q[i] <= '0;
      end
    end else begin
      hold_valid_q <= hold_valid_d;
      for (int i = 0; i < NUM_LANES; i++) begin
        if (lane_valid_in[i] && lane_ready_out[i]) begin
          hold_pix_q[i].x     <= lane_x_in[i*XW +: XW];
          hold_pix_q[i].y     <= lane_y_in[i*YW +: YW];
          hold_pix_q[i].color <= lane_color_in[i*COLOR_BITS +: COLOR_BITS];
        end
      end
    end
  end

  // Stage 1: register the granted pixel.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_valid_q <= 1'b0;
      s1_pix_q   <= '0;
    end else begin
      s1_valid_q <= gnt_valid_s;
      s1_pix_q   <= hold_pix_q[gnt_idx_s];
    end
  end

  // Range and last-pixel decode on the stage-1 pixel; widened compares keep
  // power-of-two geometries correct.
  always_comb begin
    s1_in_range_s = ({1'b0, s1_pix_q.x} < (X_W+1)'(WIDTH)) &&
                    ({1'b0, s1_pix_q.y} < (Y_W+1)'(HEIGHT));
    s1_last_s     = (s1_pix_q.x == X_W'(WIDTH - 1)) &&
                    (s1_pix_q.y == Y_W'(HEIGHT - 1));
    s1_write_s    = s1_valid_q && s1_in_range_s;
  end

  // Stage 2: write strobe, address, data, frame bookkeeping and error flag.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      cnt_q        <= '0;
      range_err_q  <= 1'b0;
    end else begin
      wr_en_q      <= s1_write_s;
      frame_done_q <= s1_write_s && s1_last_s;
      range_err_q  <= range_err_q | (s1_valid_q && !s1_in_range_s);
      if (s1_write_s) begin
        wr_addr_q <= AW'(pixel_addr(s1_pix_q.x, s1_pix_q.y));
        wr_data_q <= s1_pix_q.color;
        cnt_q     <= s1_last_s ? '0 : cnt_q + CW'(1);
      end
    end
  end

  assign wr_en_out          = wr_en_q;
  assign wr_addr_out        = wr_addr_q;
  assign wr_data_out        = wr_data_q;
  assign frame_done_out     = frame_done_q;
  assign pixels_written_out = cnt_q;
  assign range_err_out      = range_err_q;

endmodule

// File: tb/tb_pixel_writeback_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic, compared
// against a transaction-level model (pending-write queue with due edges).
module tb_pixel_writeback_arbiter;

  localparam int N = 3, W = 1280, H = 720, CB = 24;
  localparam int XW = 11, YW = 10, AW = 20, CW = 21;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic [N-1:0]    lane_valid_in;
  logic [N-1:0]    lane_ready_out;
  logic [N*XW-1:0] lane_x_in;
  logic [N*YW-1:0] lane_y_in;
  logic [N*CB-1:0] lane_color_in;
  logic            wr_en_out;
  logic [AW-1:0]   wr_addr_out;
  logic [CB-1:0]   wr_data_out;
  logic            frame_done_out;
  logic [CW-1:0]   pixels_written_out;
  logic            range_err_out;

  pixel_writeback_arbiter dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .lane_valid_in      (lane_valid_in),
    .lane_ready_out     (lane_ready_out),
    .lane_x_in          (lane_x_in),
    .lane_y_in          (lane_y_in),
    .lane_color_in      (lane_color_in),
    .wr_en_out          (wr_en_out),
    .wr_addr_out        (wr_addr_out),
    .wr_data_out        (wr_data_out),
    .frame_done_out     (frame_done_out),
    .pixels_written_out (pixels_written_out),
    .range_err_out      (range_err_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  // Lane drive values
  bit d_v [N];
  int d_x [N], d_y [N], d_c [N];
  bit acc [N];

  // Reference model
  typedef struct { int due; int x; int y; int c; } ev_t;
  ev_t evq[$];
  bit  m_hv [N];
  int  m_hx [N], m_hy [N], m_hc [N];
  int  m_rr, edge_cnt, m_cnt;
  bit  e_wr, e_fd, e_err;
  int  e_addr, e_data;
  int  wait_cnt [N];

  task automatic apply_inputs();
    for (int i = 0; i < N; i++) begin
      lane_valid_in[i]            = d_v[i];
      lane_x_in[i*XW +: XW]       = XW'(d_x[i]);
      lane_y_in[i*YW +: YW]       = YW'(d_y[i]);
      lane_color_in[i*CB +: CB]   = CB'(d_c[i]);
    end
  endtask

  task automatic model_reset();
    evq.delete();
    for (int i = 0; i < N; i++) begin
      m_hv[i] = 1'b0; acc[i] = 1'b0; wait_cnt[i] = 0;
    end
    m_rr = 0; m_cnt = 0; e_wr = 1'b0; e_fd = 1'b0; e_err = 1'b0;
  endtask

  task automatic step_model();
    bit rdy [N];
    int g, k;
    ev_t ev;
    edge_cnt++;
    for (int i = 0; i < N; i++) begin
      rdy[i] = !m_hv[i];
      acc[i] = 1'b0;
    end
    g = -1;
    for (int o = 0; o < N; o++) begin
      k = (m_rr + o) % N;
      if (g < 0 && m_hv[k]) g = k;
    end
    if (g >= 0) begin
      ev.due = edge_cnt + 1; ev.x = m_hx[g]; ev.y = m_hy[g]; ev.c = m_hc[g];
      evq.push_back(ev);
      m_hv[g] = 1'b0;
      m_rr = (g + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      if (d_v[i] && rdy[i]) begin
        m_hv[i] = 1'b1; m_hx[i] = d_x[i]; m_hy[i] = d_y[i]; m_hc[i] = d_c[i];
        acc[i] = 1'b1;
      end
    end
    e_wr = 1'b0; e_fd = 1'b0;
    if (evq.size() > 0 && evq[0].due == edge_cnt) begin
      ev = evq.pop_front();
      if (ev.x < W && ev.y < H) begin
        e_wr = 1'b1; e_addr = ev.x + W * ev.y; e_data = ev.c;
        if (ev.x == W - 1 && ev.y == H - 1) begin
          e_fd = 1'b1; m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end else begin
        e_err = 1'b1;
      end
    end
  endtask

  task automatic compare();
    check_val("wr_en", wr_en_out, e_wr);
    if (e_wr) begin
      check_val("wr_addr", wr_addr_out, e_addr);
      check_val("wr_data", wr_data_out, e_data);
    end
    check_val("frame_done", frame_done_out, e_fd);
    check_val("pix_count", pixels_written_out, m_cnt);
    check_val("range_err", range_err_out, e_err);
    for (int i = 0; i < N; i++) begin
      check_val("lane_ready", lane_ready_out[i], !m_hv[i]);
      if (!lane_ready_out[i]) begin
        wait_cnt[i]++;
        check_val("starve_bound", wait_cnt[i] <= N, 1);
      end else begin
        wait_cnt[i] = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    step_model();
    #1;
    compare();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_wr_en"}, wr_en_out, 0);
    check_val({tag, "_addr"}, wr_addr_out, 0);
    check_val({tag, "_data"}, wr_data_out, 0);
    check_val({tag, "_fd"}, frame_done_out, 0);
    check_val({tag, "_cnt"}, pixels_written_out, 0);
    check_val({tag, "_err"}, range_err_out, 0);
    check_val({tag, "_ready"}, lane_ready_out, 0);
  endtask

  // Assert reset between edges, check outputs immediately, hold, release.
  task automatic do_reset();
    #2;
    rst_in = 1'b1;
    #1;
    check_reset_outputs("rst_now");
    model_reset();
    for (int i = 0; i < N; i++) d_v[i] = 1'b0;
    apply_inputs();
    repeat (2) @(posedge clk_in);
    #1;
    check_reset_outputs("rst_hold");
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  // One pixel on an otherwise idle lane; returns at the sample of its write.
  task automatic send_one(input int lane, input int x, input int y, input int c);
    d_v[lane] = 1'b1; d_x[lane] = x; d_y[lane] = y; d_c[lane] = c;
    apply_inputs();
    tick();
    check_val("hs_ready_low", lane_ready_out[lane], 0);
    d_v[lane] = 1'b0;
    apply_inputs();
    tick();
    check_val("hs_ready_back", lane_ready_out[lane], 1);
    tick();
  endtask

  task automatic new_pixel(input int i);
    int r;
    r = $urandom_range(0, 31);
    d_x[i] = $urandom_range(0, W - 1);
    d_y[i] = $urandom_range(0, H - 1);
    if (r == 0) begin
      d_x[i] = W - 1; d_y[i] = H - 1;
    end else if (r == 1) begin
      d_x[i] = $urandom_range(W, 2047);
    end else if (r == 2) begin
      d_y[i] = $urandom_range(H, 1023);
    end
    d_c[i] = int'($urandom & 32'h00FF_FFFF);
  endtask

  int order_q[$];
  int cyc_q[$];
  int seq [N];
  int n_d0, n_d1;

  initial begin
    for (int i = 0; i < N; i++) begin
      d_v[i] = 1'b0; d_x[i] = 0; d_y[i] = 0; d_c[i] = 0;
    end
    apply_inputs();
    edge_cnt = 0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    check_reset_outputs("reset");
    @(negedge clk_in);
    rst_in = 1'b0;

    // Frame end after 9 in-range writes
    for (int i = 0; i < 9; i++) send_one(0, i, 0, 32'h100 + i);
    check_val("frame_cnt_9", pixels_written_out, 9);
    send_one(0, W - 1, H - 1, 32'hABCDEF);
    check_val("frame_wr_en", wr_en_out, 1);
    check_val("frame_addr", wr_addr_out, 921599);
    check_val("frame_done", frame_done_out, 1);
    check_val("frame_cnt_0", pixels_written_out, 0);
    tick();
    check_val("frame_done_1cyc", frame_done_out, 0);

    // Single pixel on lane 1
    send_one(1, 5, 2, 32'hFF0000);
    check_val("single_wr_en", wr_en_out, 1);
    check_val("single_addr", wr_addr_out, 2565);
    check_val("single_data", wr_data_out, 32'hFF0000);

    // Out-of-range x
    send_one(2, W, 0, 32'h123456);
    check_val("oor_no_wr", wr_en_out, 0);
    check_val("oor_err", range_err_out, 1);
    check_val("oor_cnt", pixels_written_out, 1);
    tick(); tick();
    check_val("oor_err_sticky", range_err_out, 1);

    // Contention from reset: all lanes valid with fresh coordinates
    do_reset();
    for (int i = 0; i < N; i++) begin
      seq[i] = 0; d_v[i] = 1'b1; d_x[i] = i * 10; d_y[i] = 0; d_c[i] = i;
    end
    apply_inputs();
    for (int t = 0; t < 20; t++) begin
      tick();
      if (wr_en_out) begin
        order_q.push_back(int'(wr_data_out));
        cyc_q.push_back(t);
      end
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          seq[i]++;
          d_v[i] = (t < 14);
          d_x[i] = i * 10 + seq[i]; d_y[i] = seq[i]; d_c[i] = i;
        end
      end
      apply_inputs();
    end
    check_val("rr_count", order_q.size() >= 12, 1);
    for (int j = 0; j < order_q.size(); j++) begin
      check_val("rr_order", order_q[j], j % N);
      if (j > 0) check_val("rr_back_to_back", cyc_q[j] - cyc_q[j-1], 1);
    end

    // Backpressure on lane 2: D1 waits for the slot to free up
    for (int i = 0; i < N; i++) d_v[i] = 1'b0;
    apply_inputs();
    repeat (4) tick();
    n_d0 = 0; n_d1 = 0;
    d_v[2] = 1'b1; d_x[2] = 7; d_y[2] = 7; d_c[2] = 32'h0000D0;
    apply_inputs();
    tick();
    d_x[2] = 8; d_y[2] = 8; d_c[2] = 32'h0000D1;
    apply_inputs();
    for (int t = 0; t < 7; t++) begin
      tick();
      if (wr_en_out && wr_data_out == 24'h0000D0) n_d0++;
      if (wr_en_out && wr_data_out == 24'h0000D1) n_d1++;
      if (acc[2]) begin
        d_v[2] = 1'b0;
        apply_inputs();
      end
    end
    check_val("bp_d0_once", n_d0, 1);
    check_val("bp_d1_once", n_d1, 1);

    // Randomized traffic
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) begin
        if (acc[i] || !d_v[i]) begin
          d_v[i] = ($urandom_range(0, 2) != 0);
          if (d_v[i]) new_pixel(i);
        end
      end
      apply_inputs();
      tick();
    end

    // Reset mid-flight with traffic in holds and pipeline, then quiet run
    do_reset();
    repeat (6) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
